// File: rtl/md_rx_packer.sv
// md_rx_packer: packs a byte stream into naturally aligned power-of-two
// MD RX chunks for cfs_aligner, placing each packet's first byte in a
// configurable start lane, and counts aligner error responses.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for the first byte of a packet
// ACCUM | collecting bytes until the aligned chunk is full or packet ends
// EMIT  | presenting the largest power-of-two piece of the chunk
// SPLIT | presenting the remaining pieces of a non-power-of-two chunk
module md_rx_packer #(
  parameter int ALGN_DATA_WIDTH = 32,
  localparam int N  = ALGN_DATA_WIDTH / 8,
  localparam int OW = $clog2(N),
  localparam int SW = OW + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [OW-1:0]              cfg_start_offset,
  input  logic                       s_valid,
  input  logic [7:0]                 s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic                       md_rx_valid,
  output logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
  output logic [OW-1:0]              md_rx_offset,
  output logic [SW-1:0]              md_rx_size,
  input  logic                       md_rx_ready,
  input  logic                       md_rx_err,
  output logic [7:0]                 err_cnt,
  output logic                       err_pulse,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, SPLIT} state_t;

  state_t             state, state_nxt;
  logic [OW-1:0]      base, base_nxt;
  logic [SW-1:0]      cnt, cnt_nxt;
  logic [N-1:0][7:0]  lane_buf, lane_buf_nxt;
  logic               ended, ended_nxt;
  logic               s_acc;
  logic               hs;
  logic               load;
  logic [SW-1:0]      wr_lane;
  logic [SW-1:0]      size_nxt;
  logic [SW-1:0]      hi_lane;
  logic [N-1:0][7:0]  data_nxt;

  // Largest chunk allowed at a lane: full word at lane 0, otherwise the
  // lowest set bit of the lane index (keeps every piece naturally aligned).
  function automatic logic [SW-1:0] max_chunk(input logic [OW-1:0] o);
    logic [SW-1:0] r;
    r = '0;
    if (o == '0) begin
      r = SW'(N);
    end else begin
      for (int i = OW - 1; i >= 0; i--) begin
        if (o[i]) begin
          r = '0;
          r[i] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Largest power of two not exceeding v (0 for v == 0).
  function automatic logic [SW-1:0] pow2_floor(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < SW; i++) begin
      if (v[i]) begin
        r = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  assign hs   = md_rx_valid && md_rx_ready;
  assign busy = (state != IDLE);

  // Next-state and accumulation datapath.
  always_comb begin
    state_nxt    = state;
    base_nxt     = base;
    cnt_nxt      = cnt;
    lane_buf_nxt = lane_buf;
    ended_nxt    = ended;
    s_ready      = 1'b0;
    s_acc        = 1'b0;
    wr_lane      = SW'(base) + cnt;
    case (state)
      IDLE: begin
        s_ready = !reset;
        s_acc   = s_valid && !reset;
        if (s_acc) begin
          base_nxt     = cfg_start_offset;
          cnt_nxt      = SW'(1);
          lane_buf_nxt = '0;
          for (int i = 0; i < N; i++) begin
            if (OW'(i) == cfg_start_offset) lane_buf_nxt[i] = s_data;
          end
          ended_nxt = s_last;
          if (s_last || max_chunk(cfg_start_offset) == SW'(1)) state_nxt = EMIT;
          else state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        s_ready = !reset;
        s_acc   = s_valid && !reset;
        if (s_acc) begin
          for (int i = 0; i < N; i++) begin
            if (SW'(i) == wr_lane) lane_buf_nxt[i] = s_data;
          end
          cnt_nxt   = cnt + SW'(1);
          ended_nxt = s_last;
          if (s_last || cnt_nxt == max_chunk(base)) state_nxt = EMIT;
        end
      end
      EMIT, SPLIT: begin
        if (hs) begin
          base_nxt = base + md_rx_size[OW-1:0];
          cnt_nxt  = cnt - md_rx_size;
          if (cnt_nxt != '0) begin
            state_nxt = SPLIT;
          end else if (ended) begin
            state_nxt = IDLE;
          end else begin
            state_nxt    = ACCUM;
            lane_buf_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next output piece: greedy power-of-two slice starting at the current base,
  // with lanes outside the piece forced to zero.
  always_comb begin
    size_nxt = pow2_floor(cnt_nxt);
    hi_lane  = SW'(base_nxt) + size_nxt;
    data_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) >= SW'(base_nxt) && SW'(i) < hi_lane) data_nxt[i] = lane_buf_nxt[i];
    end
    load = ((state_nxt == EMIT) || (state_nxt == SPLIT)) && (!md_rx_valid || hs);
  end

  // FSM and accumulation registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      base     <= '0;
      cnt      <= '0;
      lane_buf <= '0;
      ended    <= 1'b0;
    end else begin
      state    <= state_nxt;
      base     <= base_nxt;
      cnt      <= cnt_nxt;
      lane_buf <= lane_buf_nxt;
      ended    <= ended_nxt;
    end
  end

  // Registered MD RX outputs; held while the aligner stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_rx_valid  <= 1'b0;
      md_rx_data   <= '0;
      md_rx_offset <= '0;
      md_rx_size   <= '0;
    end else begin
      md_rx_valid <= (state_nxt == EMIT) || (state_nxt == SPLIT);
      if (load) begin
        md_rx_data   <= data_nxt;
        md_rx_offset <= base_nxt;
        md_rx_size   <= size_nxt;
      end
    end
  end

  // Error response counting; errored transfers are dropped, not retried.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= hs && md_rx_err;
      if (hs && md_rx_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_md_rx_packer.sv
// Self-checking bench for md_rx_packer (N = 4): directed packets plus random
// packets against a queue-based reference, with a decoupled output monitor.
module tb_md_rx_packer;
  localparam int N = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  off;
    logic [2:0]  size;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cfg_start_offset = 2'd0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        md_rx_valid;
  logic [31:0] md_rx_data;
  logic [1:0]  md_rx_offset;
  logic [2:0]  md_rx_size;
  logic        md_rx_ready = 1'b0;
  logic        md_rx_err = 1'b0;
  logic [7:0]  err_cnt;
  logic        err_pulse;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  xfer_t      sb[$];
  logic [7:0] pkt[$];

  bit          mon_en = 1'b0;
  bit          force_low = 1'b0;
  int          err_mode = 0;
  int          exp_cnt = 0;
  bit          exp_pulse = 1'b0;
  int          pulse_seen = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [1:0]  prev_off = '0;
  logic [2:0]  prev_size = '0;

  md_rx_packer #(.ALGN_DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .cfg_start_offset(cfg_start_offset),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .md_rx_valid(md_rx_valid), .md_rx_data(md_rx_data), .md_rx_offset(md_rx_offset),
    .md_rx_size(md_rx_size), .md_rx_ready(md_rx_ready), .md_rx_err(md_rx_err),
    .err_cnt(err_cnt), .err_pulse(err_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void exp_push(input logic [31:0] d, input int o, input int s);
    xfer_t x;
    x.data = d;
    x.off  = 2'(o);
    x.size = 3'(s);
    sb.push_back(x);
  endfunction

  // Reference: fill the aligned chunk allowed at the current lane, then
  // break it into descending powers of two.
  task automatic push_model(input int off);
    int base, pos, len, m, k, s;
    xfer_t x;
    base = off;
    pos  = 0;
    len  = pkt.size();
    while (pos < len) begin
      m = (base == 0) ? N : (base & -base);
      k = (len - pos < m) ? (len - pos) : m;
      while (k > 0) begin
        s = 1;
        while (s * 2 <= k) s = s * 2;
        x.data = '0;
        for (int j = 0; j < s; j++) x.data[(base + j) * 8 +: 8] = pkt[pos + j];
        x.off  = 2'(base);
        x.size = 3'(s);
        sb.push_back(x);
        base = (base + s) % N;
        pos  = pos + s;
        k    = k - s;
      end
    end
  endtask

  // Sends pkt; the start offset is only meaningful on the first byte, so
  // later bytes carry a random value that must be ignored.
  task automatic send_pkt(input int off);
    bit acc;
    int t;
    for (int i = 0; i < pkt.size(); i++) begin
      s_valid = 1'b0;
      cfg_start_offset = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      cfg_start_offset = (i == 0) ? 2'(off) : 2'($urandom_range(0, 3));
      s_valid = 1'b1;
      s_data  = pkt[i];
      s_last  = (i == pkt.size() - 1);
      acc = 1'b0;
      for (t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        compared++;
        mismatched++;
        $display("FAIL byte_accept: actual timeout required s_ready within 200 cycles");
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !md_rx_valid) break;
    end
    compared++;
    if (k >= 400) begin
      mismatched++;
      $display("FAIL drain: actual %0d transfers pending required 0", sb.size());
    end
  endtask

  // Aligner sink: random backpressure and error responses.
  always @(posedge clk) begin
    #1;
    if (force_low) md_rx_ready = 1'b0;
    else md_rx_ready = ($urandom_range(0, 3) != 0);
    md_rx_err = (err_mode == 2) ? 1'b1 : (err_mode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
  end

  // Monitor: pops the scoreboard on each handshake and checks hold and error behaviour.
  always @(negedge clk) begin
    xfer_t x;
    if (mon_en && !reset) begin
      chk("err_pulse", 64'(err_pulse), 64'(exp_pulse));
      chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
      if (err_pulse) pulse_seen++;
      if (prev_stall)
        chk("stall_hold", {md_rx_valid, md_rx_data, md_rx_offset, md_rx_size},
            {1'b1, prev_data, prev_off, prev_size});
      if (md_rx_valid) chk("s_ready_while_valid", 64'(s_ready), 64'd0);
      exp_pulse = 1'b0;
      if (md_rx_valid && md_rx_ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL xfer_unexpected: actual data %0h off %0d size %0d required none",
                   md_rx_data, md_rx_offset, md_rx_size);
        end else begin
          x = sb.pop_front();
          chk("xfer", {md_rx_data, md_rx_offset, md_rx_size}, {x.data, x.off, x.size});
        end
        if (md_rx_err) begin
          exp_pulse = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
      end
      prev_stall = md_rx_valid && !md_rx_ready;
      prev_data  = md_rx_data;
      prev_off   = md_rx_offset;
      prev_size  = md_rx_size;
    end
  end

  initial begin
    int off, len, k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_s_ready", 64'(s_ready), 64'd0);
    chk("reset_outputs", {md_rx_valid, md_rx_data, md_rx_offset, md_rx_size}, 64'd0);
    chk("reset_err_busy", {err_cnt, err_pulse, busy}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 64'(s_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    mon_en = 1'b1;

    // full word
    exp_push(32'h44332211, 0, 4);
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(0);
    drain();
    chk("full_busy_after", 64'(busy), 64'd0);

    // split
    exp_push(32'h0000BBAA, 0, 2);
    exp_push(32'h00CC0000, 2, 1);
    pkt = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(0);
    drain();

    // unaligned start with wrap
    exp_push(32'h00000100, 1, 1);
    exp_push(32'h03020000, 2, 2);
    exp_push(32'h00000504, 0, 2);
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pkt(1);
    drain();

    // backpressure during EMIT
    force_low = 1'b1;
    exp_push(32'h0000BBAA, 0, 2);
    exp_push(32'h00CC0000, 2, 1);
    pkt = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bp_valid_held", 64'(md_rx_valid), 64'd1);
    chk("bp_s_ready", 64'(s_ready), 64'd0);
    force_low = 1'b0;
    drain();

    // error counting
    err_mode = 2;
    pulse_seen = 0;
    exp_push(32'h00000100, 1, 1);
    exp_push(32'h03020000, 2, 2);
    exp_push(32'h00000504, 0, 2);
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pkt(1);
    drain();
    repeat (3) @(posedge clk);
    #2;
    chk("err_cnt_three", 64'(err_cnt), 64'd3);
    chk("err_pulses_three", 64'(pulse_seen), 64'd3);
    for (int p = 0; p < 300; p++) begin
      off = $urandom_range(0, 3);
      pkt = '{8'($urandom_range(0, 255))};
      push_model(off);
      send_pkt(off);
    end
    drain();
    repeat (2) @(posedge clk);
    #2;
    chk("err_cnt_saturated", 64'(err_cnt), 64'd255);

    // random packets with occasional errors
    err_mode = 1;
    for (int p = 0; p < 40; p++) begin
      off = $urandom_range(0, 3);
      len = $urandom_range(1, 10);
      pkt.delete();
      for (int b = 0; b < len; b++) pkt.push_back(8'($urandom_range(0, 255)));
      push_model(off);
      send_pkt(off);
    end
    drain();
    err_mode = 0;
    repeat (2) @(posedge clk);

    // reset asserted while a transfer is presented
    mon_en = 1'b0;
    force_low = 1'b1;
    pkt = '{8'h5A, 8'h6B, 8'h7C};
    send_pkt(0);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (md_rx_valid) break;
    end
    chk("rst_mid_valid_before", 64'(md_rx_valid), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_valid_drop", 64'(md_rx_valid), 64'd0);
    chk("rst_mid_busy_err", {busy, s_ready, err_cnt}, 64'd0);
    sb.delete();
    exp_cnt = 0;
    exp_pulse = 1'b0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    force_low = 1'b0;
    mon_en = 1'b1;
    exp_push(32'h44332211, 0, 4);
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
